// File: rtl/ultrasound_echo_responder.sv
// Ultrasound ranging module emulator: responder end of the trigger/echo protocol.
// Accepts a trigger that stays high for at least MIN_TRIGGER_CYCLES samples, waits
// HOLDOFF_CYCLES, then drives an echo pulse whose width encodes the programmed distance,
// followed by a RECOVERY_CYCLES dead time.
//
// Ports:
//   clock          - system clock
//   reset          - synchronous active-high reset
//   power          - module power enable; low acts as a held reset but keeps echo_count
//   trigger        - trigger command from the main FPGA
//   distance       - target distance in units, sampled when the trigger is accepted
//   target_present - 1 = target in range, 0 = no target (MAX_ECHO_CYCLES echo)
//   echo           - registered echo pulse
//   busy           - registered, high in every state except IDLE
//   echo_count     - completed echoes, wraps 255 -> 0
//   state          - current state encoding, for debug
module ultrasound_echo_responder #(
  parameter int unsigned MIN_TRIGGER_CYCLES = 10,
  parameter int unsigned HOLDOFF_CYCLES     = 4,
  parameter int unsigned CYCLES_PER_UNIT    = 2,
  parameter int unsigned MAX_ECHO_CYCLES    = 600,
  parameter int unsigned RECOVERY_CYCLES    = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       power,
  input  logic       trigger,
  input  logic [7:0] distance,
  input  logic       target_present,
  output logic       echo,
  output logic       busy,
  output logic [7:0] echo_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StTrig    = 3'd1,
    StHoldoff = 3'd2,
    StEcho    = 3'd3,
    StRecover = 3'd4
  } state_e;

  localparam logic [15:0] MinTrig     = 16'(MIN_TRIGGER_CYCLES);
  localparam logic [15:0] HoldoffLast = 16'(HOLDOFF_CYCLES - 1);
  localparam logic [15:0] RecoverLast = 16'(RECOVERY_CYCLES - 1);
  localparam logic [15:0] CyclesUnit  = 16'(CYCLES_PER_UNIT);
  localparam logic [15:0] MaxEcho     = 16'(MAX_ECHO_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;      // shared per-state counter
  logic [15:0] width_q, width_d;  // echo width latched at trigger acceptance
  logic        echo_q, echo_d;
  logic        busy_q;
  logic [7:0]  echo_count_q, echo_count_d;
  logic        trigger_prev_q;

  logic [15:0] dist_eff;
  logic [15:0] new_width;

  // Distance 0 is treated as 1 unit so a present target never yields a zero-width echo.
  assign dist_eff  = (distance == 8'd0) ? 16'd1 : {8'd0, distance};
  assign new_width = target_present ? (dist_eff * CyclesUnit) : MaxEcho;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    width_d      = width_q;
    echo_d       = 1'b0;
    echo_count_d = echo_count_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = 16'd0;
        // Edge detect: a trigger already high on entry to IDLE must drop first.
        if (trigger && !trigger_prev_q) begin
          state_d = StTrig;
          cnt_d   = 16'd1;
        end
      end
      StTrig: begin
        if (trigger) begin
          if (cnt_q < MinTrig) cnt_d = cnt_q + 16'd1;
        end else if (cnt_q >= MinTrig) begin
          state_d = StHoldoff;
          cnt_d   = 16'd0;
          width_d = new_width;
        end else begin
          state_d = StIdle;
          cnt_d   = 16'd0;
        end
      end
      StHoldoff: begin
        if (cnt_q == HoldoffLast) begin
          state_d = StEcho;
          cnt_d   = 16'd0;
          echo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StEcho: begin
        if (cnt_q == width_q - 16'd1) begin
          state_d      = StRecover;
          cnt_d        = 16'd0;
          echo_count_d = echo_count_q + 8'd1;
        end else begin
          cnt_d  = cnt_q + 16'd1;
          echo_d = 1'b1;
        end
      end
      StRecover: begin
        if (cnt_q == RecoverLast) begin
          state_d = StIdle;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 16'd0;
      end
    endcase

    // Power loss aborts any pulse in flight; an aborted echo is not counted.
    if (!power) begin
      state_d      = StIdle;
      cnt_d        = 16'd0;
      width_d      = 16'd0;
      echo_d       = 1'b0;
      echo_count_d = echo_count_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= 16'd0;
      width_q        <= 16'd0;
      echo_q         <= 1'b0;
      busy_q         <= 1'b0;
      echo_count_q   <= 8'd0;
      trigger_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      width_q        <= width_d;
      echo_q         <= echo_d;
      busy_q         <= (state_d != StIdle);
      echo_count_q   <= echo_count_d;
      trigger_prev_q <= power & trigger;
    end
  end

  assign echo       = echo_q;
  assign busy       = busy_q;
  assign echo_count = echo_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_ultrasound_echo_responder.sv
// Self-checking bench for ultrasound_echo_responder. A timeline model predicts every
// output on every cycle; directed scenarios add literal checks on pulse widths, state
// durations and echo counts.
module tb_ultrasound_echo_responder;

  localparam int MinTrig  = 10;
  localparam int Holdoff  = 4;
  localparam int PerUnit  = 2;
  localparam int MaxEcho  = 600;
  localparam int Recovery = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       power = 1'b0;
  logic       trigger = 1'b0;
  logic [7:0] distance = 8'd0;
  logic       target_present = 1'b1;
  logic       echo;
  logic       busy;
  logic [7:0] echo_count;
  logic [2:0] state;

  ultrasound_echo_responder #(
    .MIN_TRIGGER_CYCLES(MinTrig),
    .HOLDOFF_CYCLES    (Holdoff),
    .CYCLES_PER_UNIT   (PerUnit),
    .MAX_ECHO_CYCLES   (MaxEcho),
    .RECOVERY_CYCLES   (Recovery)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .power         (power),
    .trigger       (trigger),
    .distance      (distance),
    .target_present(target_present),
    .echo          (echo),
    .busy          (busy),
    .echo_count    (echo_count),
    .state         (state)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  // Model: phase 0 idle, 1 collecting trigger, 2 pulse timeline (holdoff/echo/recover).
  int m_phase = 0;
  int m_tcnt = 0;
  int m_k = 0;
  int m_w = 0;
  int m_count = 0;
  bit m_prev = 1'b0;
  int exp_state;
  bit exp_echo, exp_busy;

  // DUT-observed measurements for the literal checks.
  int last_dur[8];
  int prev_s = 0, run_s = 0;
  int erun = 0, last_w = 0, rises = 0;
  bit echo_prev = 1'b0;

  task automatic model_step();
    int d;
    if (reset) begin
      m_phase = 0; m_count = 0; m_prev = 1'b0;
    end else if (!power) begin
      m_phase = 0; m_prev = 1'b0;
    end else begin
      case (m_phase)
        0: if (trigger && !m_prev) begin m_phase = 1; m_tcnt = 1; end
        1: begin
          if (trigger) begin
            m_tcnt = (m_tcnt + 1 > MinTrig) ? MinTrig : m_tcnt + 1;
          end else if (m_tcnt >= MinTrig) begin
            d = (distance == 0) ? 1 : int'(distance);
            m_w = target_present ? d * PerUnit : MaxEcho;
            m_phase = 2; m_k = 0;
          end else begin
            m_phase = 0;
          end
        end
        default: begin
          m_k++;
          if (m_k == Holdoff + m_w) m_count = (m_count + 1) % 256;
          if (m_k == Holdoff + m_w + Recovery) m_phase = 0;
        end
      endcase
      m_prev = trigger;
    end
    if (m_phase == 0) exp_state = 0;
    else if (m_phase == 1) exp_state = 1;
    else if (m_k < Holdoff) exp_state = 2;
    else if (m_k < Holdoff + m_w) exp_state = 3;
    else exp_state = 4;
    exp_echo = (exp_state == 3);
    exp_busy = (exp_state != 0);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
      #1;
      cycle++;
      vectors++;
      if (int'(state) != exp_state || echo !== exp_echo || busy !== exp_busy ||
          int'(echo_count) != m_count) begin
        miscompares++;
        $display("FAIL cycle %0d: state=%0d echo=%0b busy=%0b count=%0d, expected state=%0d echo=%0b busy=%0b count=%0d",
                 cycle, state, echo, busy, echo_count, exp_state, exp_echo, exp_busy, m_count);
      end
      if (int'(state) == prev_s) run_s++;
      else begin last_dur[prev_s] = run_s; prev_s = int'(state); run_s = 1; end
      if (echo) begin
        if (!echo_prev) rises++;
        erun++;
      end else if (erun > 0) begin
        last_w = erun; erun = 0;
      end
      echo_prev = echo;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_trigger(input int n);
    @(negedge clock);
    trigger = 1'b1;
    repeat (n) @(negedge clock);
    trigger = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(state) == s) break;
      @(negedge clock);
    end
    if (int'(state) != s) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_state: state=%0d, expected %0d within %0d cycles", state, s, budget);
    end
  endtask

  task automatic echo_once(input int n);
    pulse_trigger(n);
    wait_state(0, 2000);
  endtask

  initial begin
    // Reset state
    cycles(3);
    check("reset_state", int'(state), 0);
    check("reset_echo", int'(echo), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(echo_count), 0);
    reset = 1'b0;
    power = 1'b1;
    cycles(2);

    // Basic echo
    distance = 8'd20; target_present = 1'b1;
    echo_once(10);
    check("basic_trig_cycles", last_dur[1], 10);
    check("basic_holdoff_cycles", last_dur[2], 4);
    check("basic_echo_width", last_w, 40);
    check("basic_recover_cycles", last_dur[4], 6);
    check("basic_count", int'(echo_count), 1);

    // Short trigger
    cycles(2);
    pulse_trigger(9);
    cycles(3);
    check("short_trig_cycles", last_dur[1], 9);
    check("short_state", int'(state), 0);
    check("short_no_echo", rises, 1);
    check("short_count", int'(echo_count), 1);
    echo_once(10);
    check("after_short_count", int'(echo_count), 2);

    // Widths
    target_present = 1'b0; cycles(1);
    echo_once(10);
    check("no_target_width", last_w, 600);
    target_present = 1'b1; distance = 8'd0; cycles(1);
    echo_once(10);
    check("dist0_width", last_w, 2);
    distance = 8'd255; cycles(1);
    echo_once(12);
    check("dist255_width", last_w, 510);
    distance = 8'd20;
    pulse_trigger(10);
    cycles(2);
    distance = 8'd7;
    wait_state(0, 2000);
    check("latched_width", last_w, 40);
    check("widths_count", int'(echo_count), 6);

    // Retrigger during ECHO held through RECOVER
    distance = 8'd20;
    pulse_trigger(10);
    wait_state(3, 100);
    trigger = 1'b1;
    wait_state(0, 200);
    cycles(5);
    check("retrig_ignored_state", int'(state), 0);
    check("retrig_count", int'(echo_count), 7);
    trigger = 1'b0;
    cycles(1);
    echo_once(10);
    check("second_echo_count", int'(echo_count), 8);

    // Reset mid-ECHO
    pulse_trigger(10);
    wait_state(3, 100);
    cycles(5);
    reset = 1'b1;
    cycles(1);
    check("abort_echo", int'(echo), 0);
    check("abort_state", int'(state), 0);
    check("abort_count", int'(echo_count), 0);
    reset = 1'b0;
    cycles(2);

    // Power drop mid-ECHO after one completed echo
    echo_once(10);
    pulse_trigger(10);
    wait_state(3, 100);
    cycles(3);
    power = 1'b0;
    cycles(1);
    check("pwr_echo", int'(echo), 0);
    check("pwr_state", int'(state), 0);
    check("pwr_count", int'(echo_count), 1);
    cycles(3);
    power = 1'b1;
    cycles(2);

    // Wrap: 255 more completed echoes takes the count from 1 back to 0
    distance = 8'd0;
    for (int i = 0; i < 255; i++) begin
      echo_once(10);
      cycles(1);
    end
    check("wrap_count", int'(echo_count), 0);

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ultrasound_echo_responder.md
Name: ultrasound_echo_responder

Overview:
- Synthesizable emulator of one ultrasound ranging module: the responder end of the trigger/echo protocol that the location calculator drives.
- Waits for a valid trigger pulse, then holds off, then returns an echo pulse whose width encodes a programmed distance.
- Instantiated per channel on the rover/test FPGA so the main FPGA's trigger/measure/median path runs against known distances without physical sensors.

Parameters:
- MIN_TRIGGER_CYCLES, 10, minimum consecutive high samples of trigger for a valid trigger
- HOLDOFF_CYCLES, 4, cycles between trigger acceptance and echo rising (>=1)
- CYCLES_PER_UNIT, 2, echo-high cycles per distance unit
- MAX_ECHO_CYCLES, 600, echo width when no target is present
- RECOVERY_CYCLES, 6, dead time after echo falls before returning to IDLE (>=1)

Ports:
- clock, input, 1, system clock
- reset, input, 1, synchronous active-high reset
- power, input, 1, module power enable; low behaves as a held reset except echo_count is kept
- trigger, input, 1, trigger command from the main FPGA
- distance, input, 8, target distance in units
- target_present, input, 1, 1 = target in range; 0 = no echo target (timeout width)
- echo, output, 1, echo pulse, registered
- busy, output, 1, high in every state except IDLE
- echo_count, output, 8, number of completed echoes, wraps 255->0
- state, output, 3, current state encoding, for debug

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: echo=0, busy=0, echo_count=0, state=IDLE(0), all internal counters 0, trigger_prev=0.
- power=0: next cycle state=IDLE, echo=0, counters cleared; echo_count holds. Reset has priority over power.
- States (encoding): IDLE=0, TRIG=1, HOLDOFF=2, ECHO=3, RECOVER=4. Unused codes return to IDLE.
- IDLE -> TRIG on a sampled rising edge: trigger=1 and trigger_prev=0. The trigger counter loads 1.
  - A trigger that is already high on entering IDLE is ignored until it goes low and rises again.
- TRIG, trigger=1: counter increments, saturating at MIN_TRIGGER_CYCLES.
- TRIG, trigger=0:
  - Counter >= MIN_TRIGGER_CYCLES: go to HOLDOFF. Latch width W: W=MAX_ECHO_CYCLES if target_present=0, else max(distance,1)*CYCLES_PER_UNIT.
  - Otherwise (short trigger): go to IDLE, no echo.
- distance and target_present are sampled only at that transition; later changes do not affect the pulse in flight.
- W arithmetic is 16-bit unsigned. Defaults give a maximum of 600.
- HOLDOFF: state lasts exactly HOLDOFF_CYCLES cycles, then ECHO.
- ECHO: echo=1 for exactly W consecutive cycles, registered with the state.
  - The echo falls on the cycle the state becomes RECOVER.
  - echo_count increments on that cycle.
- RECOVER: lasts exactly RECOVERY_CYCLES cycles, then IDLE.
- trigger activity in HOLDOFF, ECHO and RECOVER is ignored. trigger_prev keeps updating every cycle.
- Reset or power loss during any state aborts the pulse:
  - echo low on the next cycle.
  - An aborted echo does not increment echo_count.
- busy = (state != IDLE), registered.

Test Plan:
- Basic echo: reset, power=1, distance=20, target_present=1, trigger high 10 cycles then low -> state 1 for 10 cycles, then 2 for 4 cycles, then echo high exactly 40 cycles, state 4 for 6 cycles, then 0; echo_count=1.
- Short trigger: trigger high 9 cycles -> no echo; state returns to 0 the cycle after trigger low is sampled; echo_count unchanged. Then trigger high 10 cycles -> normal echo.
- Widths:
  - target_present=0 -> echo 600 cycles.
  - distance=0 -> 2 cycles.
  - distance=255 -> 510 cycles.
  - distance changed to 7 mid-HOLDOFF -> width remains the latched value.
- Retrigger rules:
  - trigger raised during ECHO and held through RECOVER -> no second TRIG entry.
  - Drop then raise for 10 cycles -> second echo; echo_count=2.
- Abort: reset asserted mid-ECHO -> echo=0, state=0, echo_count=0 next cycle.
- Power drop: power dropped mid-ECHO after one completed echo -> echo=0, state=0 next cycle, echo_count stays 1.
- Wrap: 256 completed echoes -> echo_count returns to 0.
